// File: rtl/spi_master.sv
// SPI master: shifts a 10-bit {cmd,din} frame out on MOSI, MSB first.
// Read-data frames (cmd=11) add TURN idle cycles, then capture one byte from MISO.
module spi_master #(
  parameter int unsigned TURN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       MISO,
  output logic       SS_n,
  output logic       MOSI,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       busy
);

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TURN_W  = 4;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TURNA,
    RECV,
    DONE
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  frame_sh;
  logic                is_read;
  logic [CNT_W-1:0]    bit_cnt;
  logic [TURN_W-1:0]   turn_cnt;
  logic [BYTE_W-1:0]   rx_sh;

  // frame_sh holds the bits not yet on MOSI, next bit at [FRAME_W-1]
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_sh   <= '0;
      is_read    <= 1'b0;
      bit_cnt    <= '0;
      turn_cnt   <= '0;
      rx_sh      <= '0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frame_sh <= {cmd[0], din, 1'b0};
            is_read  <= (cmd == 2'b11);
            MOSI     <= cmd[1];
            SS_n     <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
            MOSI     <= 1'b0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            if (is_read) begin
              state <= TURNA;
            end else begin
              SS_n  <= 1'b1;
              state <= DONE;
            end
          end else begin
            MOSI     <= frame_sh[FRAME_W-1];
            frame_sh <= {frame_sh[FRAME_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        TURNA: begin
          if (turn_cnt == TURN_W'(TURN - 1)) begin
            state <= RECV;
          end else begin
            turn_cnt <= turn_cnt + 1'b1;
          end
        end
        RECV: begin
          rx_sh <= {rx_sh[BYTE_W-2:0], MISO};
          if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
            dout       <= {rx_sh[BYTE_W-2:0], MISO};
            dout_valid <= 1'b1;
            SS_n       <= 1'b1;
            state      <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master.
module tb_spi_master;

  localparam int unsigned TURN = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       MISO;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_dout = 8'h00;

  spi_master #(.TURN(TURN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .din       (din),
    .MISO      (MISO),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one frame and follow it until busy drops; MISO serves rx during RECV.
  task automatic do_frame(input string tag, input logic [1:0] c, input logic [7:0] d,
                          input logic [7:0] rx, input bit glitch, input bit hold);
    logic [9:0] exp_bits;
    logic [9:0] got_bits;
    int low;
    int busy_n;
    int pulses;
    int pulses_low;
    int exp_low;
    exp_bits   = {c, d};
    got_bits   = '0;
    low        = 0;
    busy_n     = 0;
    pulses     = 0;
    pulses_low = 0;
    exp_low    = (c == 2'b11) ? 10 + int'(TURN) + 8 : 10;
    cmd   = c;
    din   = d;
    start = 1'b1;
    tick();
    start = hold;
    while (busy && busy_n < 64) begin
      if (!SS_n) begin
        if (low < 10) got_bits[9-low] = MOSI;
        if (low >= 10 + int'(TURN) && low < 18 + int'(TURN))
          MISO = rx[7-(low-10-int'(TURN))];
        else
          MISO = 1'b0;
        low++;
      end
      if (dout_valid) begin
        pulses++;
        if (!SS_n) pulses_low++;
      end
      busy_n++;
      if (glitch) begin
        start = (busy_n == 3 || busy_n == 9);
        cmd   = 2'b11;
        din   = ~d;
      end
      tick();
    end
    MISO = 1'b0;
    if (glitch) start = 1'b0;
    if (c == 2'b11) exp_dout = rx;
    check({tag, " mosi_bits"}, 32'(got_bits), 32'(exp_bits));
    check({tag, " ss_low_cycles"}, 32'(low), 32'(exp_low));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_low + 1));
    check({tag, " valid_pulses"}, 32'(pulses), (c == 2'b11) ? 32'd1 : 32'd0);
    check({tag, " valid_while_ss_low"}, 32'(pulses_low), 32'd0);
    check({tag, " idle_ss_n"}, 32'(SS_n), 32'd1);
    check({tag, " idle_mosi"}, 32'(MOSI), 32'd0);
    check({tag, " dout"}, 32'(dout), 32'(exp_dout));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cmd   = 2'b00;
    din   = 8'h00;
    MISO  = 1'b0;
    repeat (3) tick();
    check("rst ss_n", 32'(SS_n), 32'd1);
    check("rst mosi", 32'(MOSI), 32'd0);
    check("rst dout", 32'(dout), 32'h00);
    check("rst dout_valid", 32'(dout_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle busy", 32'(busy), 32'd0);

    // first frame after reset: write-addr 0xA5
    start = 1'b1;
    cmd   = 2'b00;
    din   = 8'hA5;
    tick();
    start = 1'b0;
    check("wa first busy", 32'(busy), 32'd1);
    check("wa first ss_n", 32'(SS_n), 32'd0);
    check("wa first mosi", 32'(MOSI), 32'd0);
    repeat (9) tick();
    check("wa last mosi", 32'(MOSI), 32'd1);
    tick();
    check("wa done ss_n", 32'(SS_n), 32'd1);
    check("wa done busy", 32'(busy), 32'd1);
    tick();
    check("wa idle busy", 32'(busy), 32'd0);
    check("wa dout", 32'(dout), 32'h00);

    do_frame("wa_a5", 2'b00, 8'hA5, 8'h00, 1'b0, 1'b0);
    do_frame("rd_3c", 2'b11, 8'h00, 8'h3C, 1'b0, 1'b0);
    do_frame("wd_glitch", 2'b01, 8'h6E, 8'h00, 1'b1, 1'b0);
    check("glitch no relaunch", 32'(busy), 32'd0);
    tick();
    check("glitch still idle", 32'(busy), 32'd0);
    do_frame("rd_81", 2'b11, 8'h12, 8'h81, 1'b0, 1'b0);
    do_frame("wd_55", 2'b01, 8'h55, 8'hFF, 1'b0, 1'b0);
    do_frame("ra_ff", 2'b10, 8'hC0, 8'hFF, 1'b0, 1'b0);

    // start held high: back-to-back read-addr frames
    for (int k = 0; k < 3; k++) begin
      do_frame("b2b_ra_ff", 2'b10, 8'hFF, 8'h00, 1'b0, 1'b1);
    end
    start = 1'b0;
    tick();
    check("b2b stop busy", 32'(busy), 32'd0);

    // reset during the 5th RECV cycle of a read-data frame
    start = 1'b1;
    cmd   = 2'b11;
    din   = 8'h00;
    tick();
    start = 1'b0;
    MISO  = 1'b1;
    repeat (9 + TURN + 1 + 4) tick();
    check("mid ss_n low", 32'(SS_n), 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid rst ss_n", 32'(SS_n), 32'd1);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst dout", 32'(dout), 32'h00);
    check("mid rst valid", 32'(dout_valid), 32'd0);
    rst_n = 1'b1;
    MISO  = 1'b0;
    exp_dout = 8'h00;
    repeat (20) begin
      tick();
      check("post rst no valid", 32'(dout_valid), 32'd0);
    end
    check("post rst ss_n", 32'(SS_n), 32'd1);

    do_frame("rd_c3_after_rst", 2'b11, 8'h5A, 8'hC3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: TURN, default 2, number of turnaround cycles between the last MOSI bit and the first MISO sample in a read-data frame (range 1..15).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request a frame; sampled only in IDLE.
REQ-005 cmd  input  2  frame command (00 write-addr, 01 write-data, 10 read-addr, 11 read-data); captured with start.
REQ-006 din  input  8  frame payload; captured with start.
REQ-007 MISO  input  1  serial data from the slave.
REQ-008 SS_n  output  1  active-low slave select, registered.
REQ-009 MOSI  output  1  serial data to the slave, registered, MSB first.
REQ-010 dout  output  8  byte received in the last read-data frame.
REQ-011 dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have five states: IDLE, SEND, TURNA, RECV, DONE.
REQ-014 IDLE: SS_n=1, MOSI=0; start=1 at an edge -> capture frame={cmd,din} (10 bits), set bit counter to 0, go to SEND.
REQ-015 SEND: SS_n=0 and MOSI=frame[9-n] for n=0..9, one bit per cycle; the first bit appears the cycle after start is sampled.
REQ-016 Exit SEND after the 10th bit: cmd=11 -> TURNA, otherwise -> DONE.
REQ-017 TURNA: SS_n=0, MOSI=0 for exactly TURN cycles, then -> RECV.
REQ-018 RECV: SS_n=0, MOSI=0; sample MISO at 8 consecutive rising edges into a shift register, MSB first.
REQ-019 At the 8th RECV edge, dout SHALL be set to the assembled byte, dout_valid SHALL be set to 1 for one cycle, and the FSM SHALL go to DONE.
REQ-020 DONE: SS_n=1, MOSI=0 for exactly one cycle, then -> IDLE; this guarantees a minimum one-cycle SS_n-high gap between frames.
REQ-021 Frame length with SS_n low: 10 cycles for cmd 00/01/10, and 10+TURN+8 cycles for cmd 11.
REQ-022 start while busy=1 SHALL be ignored; cmd and din SHALL NOT be re-captured mid-frame.
REQ-023 start held high continuously SHALL launch back-to-back frames separated by the DONE cycle plus one IDLE cycle.
REQ-024 dout SHALL hold its value until the next completed read-data frame; write and read-addr frames SHALL NOT change it.
REQ-025 busy SHALL rise the cycle after start is sampled and fall on entry to IDLE.

Reset
REQ-026 While rst_n=0 at an edge: state=IDLE, SS_n=1, MOSI=0, dout=0x00, dout_valid=0, busy=0, and the counters and shift registers are cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame: SS_n=1 after the next edge, no dout_valid pulse, dout=0.
REQ-028 The first start accepted after reset release SHALL produce a complete, correct frame.

Verification
REQ-029 start, cmd=00, din=0xA5 -> SS_n low for 10 cycles, MOSI=0,0,1,0,1,0,0,1,0,1; then SS_n high; dout_valid stays 0; dout=0x00.
REQ-030 start, cmd=11, din=0x00, TURN=2, MISO drives 0x3C MSB first during RECV -> SS_n low for 20 cycles, dout=0x3C, one dout_valid pulse coincident with the DONE cycle.
REQ-031 start pulses during the cmd=01 frame at cycles 3 and 9 -> ignored, with exactly one 10-bit frame and busy high for 11 cycles.
REQ-032 rst_n=0 at the 5th RECV cycle of a read-data frame -> SS_n=1, busy=0, dout=0x00, and no dout_valid pulse.
REQ-033 start held high, cmd=10, din=0xFF -> repeated frames MOSI=1,0,1,1,1,1,1,1,1,1, each followed by at least one SS_n-high cycle.
REQ-034 Read 0x81, then write-data 0x55 -> dout remains 0x81 after the write frame.
